// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: one CPU pipeline stage register with a valid/ready handshake.
// A two-entry skid (main + skid) keeps READY_OUT a pure register output.
// FLUSH discards everything held, including the entry offered on the same edge.
// Control bits are zeroed whenever the main entry becomes invalid, so a bubble
// never carries RegWrite/Jump/Branch downstream.
// Optional macro PIPE_STALL_CNT_EN adds a saturating stall counter (STALL_CNT_OUT).
// All state changes on the falling edge of clk; rst_n is synchronous, active low.
module pipe_stage_buf #(
    parameter int DATA_W      = 32,
    parameter int CTRL_W      = 8,
    parameter int STALL_CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              FLUSH,
    input  logic              VALID_IN,
    output logic              READY_OUT,
    input  logic [DATA_W-1:0] DATA_IN,
    input  logic [CTRL_W-1:0] CTRL_IN,
    output logic              VALID_OUT,
    input  logic              READY_IN,
    output logic [DATA_W-1:0] DATA_OUT,
    output logic [CTRL_W-1:0] CTRL_OUT,
`ifdef PIPE_STALL_CNT_EN
    output logic [1:0]             OCC_OUT,
    output logic [STALL_CNT_W-1:0] STALL_CNT_OUT
`else
    output logic [1:0]             OCC_OUT
`endif
);

    // State encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    logic                r_m_valid;
    logic [DATA_W-1:0]   r_m_data;
    logic [CTRL_W-1:0]   r_m_ctrl;
    logic                r_s_valid;
    logic [DATA_W-1:0]   r_s_data;
    logic [CTRL_W-1:0]   r_s_ctrl;

    logic                w_m_valid_next;
    logic [DATA_W-1:0]   w_m_data_next;
    logic [CTRL_W-1:0]   w_m_ctrl_next;
    logic                w_s_valid_next;
    logic [DATA_W-1:0]   w_s_data_next;
    logic [CTRL_W-1:0]   w_s_ctrl_next;

    logic                w_accept;
    logic                w_drain;

    // READY_OUT comes straight from the skid-valid flop, so READY_IN never
    // reaches it combinationally.
    assign READY_OUT = ~r_s_valid;
    assign VALID_OUT = r_m_valid;
    assign DATA_OUT  = r_m_data;
    assign CTRL_OUT  = r_m_ctrl;
    assign OCC_OUT   = r_state;

    assign w_accept  = VALID_IN & READY_OUT;
    assign w_drain   = r_m_valid & READY_IN;

    // Next-state and next-entry logic; FLUSH overrides normal handshaking.
    always_comb begin
        w_state_next   = r_state;
        w_m_valid_next = r_m_valid;
        w_m_data_next  = r_m_data;
        w_m_ctrl_next  = r_m_ctrl;
        w_s_valid_next = r_s_valid;
        w_s_data_next  = r_s_data;
        w_s_ctrl_next  = r_s_ctrl;

        if (FLUSH) begin
            // Data registers keep their contents; only valid/control are killed.
            w_state_next   = ST_EMPTY;
            w_m_valid_next = 1'b0;
            w_m_ctrl_next  = '0;
            w_s_valid_next = 1'b0;
            w_s_ctrl_next  = '0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_m_valid_next = 1'b1;
                        w_m_data_next  = DATA_IN;
                        w_m_ctrl_next  = CTRL_IN;
                        w_state_next   = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_drain) begin
                        w_m_data_next  = DATA_IN;
                        w_m_ctrl_next  = CTRL_IN;
                    end else if (w_accept) begin
                        w_s_valid_next = 1'b1;
                        w_s_data_next  = DATA_IN;
                        w_s_ctrl_next  = CTRL_IN;
                        w_state_next   = ST_FULL;
                    end else if (w_drain) begin
                        w_m_valid_next = 1'b0;
                        w_m_ctrl_next  = '0;
                        w_state_next   = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // READY_OUT is low here, so VALID_IN cannot be accepted.
                    if (w_drain) begin
                        w_m_data_next  = r_s_data;
                        w_m_ctrl_next  = r_s_ctrl;
                        w_s_valid_next = 1'b0;
                        w_s_ctrl_next  = '0;
                        w_state_next   = ST_ONE;
                    end
                end
                default: begin
                    w_state_next   = ST_EMPTY;
                    w_m_valid_next = 1'b0;
                    w_m_ctrl_next  = '0;
                    w_s_valid_next = 1'b0;
                    w_s_ctrl_next  = '0;
                end
            endcase
        end
    end

    // State and entry registers; reset clears every field so nothing survives.
    always_ff @(negedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_EMPTY;
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_m_ctrl  <= '0;
            r_s_valid <= 1'b0;
            r_s_data  <= '0;
            r_s_ctrl  <= '0;
        end else begin
            r_state   <= w_state_next;
            r_m_valid <= w_m_valid_next;
            r_m_data  <= w_m_data_next;
            r_m_ctrl  <= w_m_ctrl_next;
            r_s_valid <= w_s_valid_next;
            r_s_data  <= w_s_data_next;
            r_s_ctrl  <= w_s_ctrl_next;
        end
    end

`ifdef PIPE_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    assign STALL_CNT_OUT = r_stall_cnt;

    // Count edges where a valid output is held back downstream; saturates.
    always_ff @(negedge clk) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (r_m_valid && !READY_IN && !FLUSH && !(&r_stall_cnt)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end
`endif

endmodule
